lbist_seq_ctrl: RTL and testbench
=================================

// Module: lbist_seq_ctrl
// PURPOSE
// - Sequences one LBIST session over the pattern datapath:
//   LFSR pattern generator -> buffer -> distance/compare stage -> result RAM.
// - Run order: seed the LFSR, run NPAT patterns, write each result into RAM, then read the RAM back.
// - Read-back data is compacted into an 8-bit MISR signature and compared with a golden value.
// - Sits above the datapath top and drives its LFSR controls and the RAM wr/addr ports.
// PARAMETERS
// - DW      8      data width of RAM read data and signature
// - AW      8      RAM address width; constraint NPAT <= 2**AW
// - NPAT    200    patterns per session (>=1)
// - LAT     2      cycles from lfsr_en-high to valid result at RAM write port (>=1)
// - SEED    8'h01  LFSR seed loaded at session start (must be nonzero)
// - GOLDEN  8'hA5  expected final MISR signature
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   asynchronous, active-high reset
// - start      in   1   begin session; sampled only in IDLE
// - abort      in   1   cancel session; return to IDLE
// - ram_rdata  in   DW  RAM read data, valid 1 cycle after ram_addr
// - lfsr_ld    out  1   load seed into LFSR
// - lfsr_en    out  1   advance LFSR one step
// - seed       out  DW  seed value; constant SEED
// - ram_wr     out  1   RAM write enable
// - ram_addr   out  AW  RAM address
// - busy       out  1   high in any state other than IDLE
// - done       out  1   1-cycle pulse at session end
// - pass       out  1   signature==GOLDEN; held until next start
// - signature  out  DW  current MISR value
// BEHAVIOUR
// - Reset: all outputs and registers 0 (except seed=SEED); state IDLE. Applies at once, including mid-session.
// - All outputs are registered. Cycle n means the state entered at edge n.
// - States and timing:
//   - IDLE: start=1 at edge 0 -> SEED.
//   - SEED, cycle 1: lfsr_ld=1; signature cleared; pass cleared.
//   - RUN, cycles 2..NPAT+1: lfsr_en=1; pattern counter counts to NPAT.
//     ram_wr=1 from cycle 2+LAT for exactly NPAT cycles; ram_addr=0..NPAT-1, +1 per write.
//   - FLUSH: the LAT cycles after RUN; ram_wr continues until all NPAT writes are done.
//   - READ: ram_wr=0; ram_addr=0..NPAT-1 over NPAT cycles, plus 1 drain cycle; NPAT+1 cycles total.
//     - Each valid ram_rdata updates the MISR: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ ram_rdata.
//   - DONE, 1 cycle: done=1; pass=(signature==GOLDEN). Then IDLE.
// - ram_addr wraps only if NPAT = 2**AW. The last address is 2**AW-1; there is no wrap inside a session.
// - start while busy is ignored. abort has priority over start and over every state transition.
// - abort in any non-IDLE state, sampled at edge k:
//   - IDLE at k+1; lfsr_en, ram_wr, busy all 0 at k+1.
//   - No done pulse; pass stays 0.
// - start and abort both high in IDLE: stay in IDLE.
// CONFIGURATION
// - LBIST_LOOP_EN defined:
//   - Adds input loop (1 bit) and output fail_cnt (8 bits).
//   - DONE goes to SEED instead of IDLE while loop=1.
//   - fail_cnt increments, saturating at 8'hFF, on each DONE with a signature mismatch.
//   - fail_cnt is cleared by reset or by start accepted in IDLE.
// - LBIST_LOOP_EN undefined: neither port exists; DONE always goes to IDLE.
// TESTING
// - NPAT=4, LAT=2, start pulse at edge 0:
//   - lfsr_ld=1 in cycle 1; lfsr_en=1 in cycles 2-5.
//   - ram_wr=1 in cycles 4-7 with addr 0,1,2,3.
//   - READ in cycles 8-12; done=1 in cycle 13.
// - NPAT=4, ram_rdata model returns 8'h00 -> signature=8'h00 at DONE.
//   - pass=0 with GOLDEN=8'hA5; pass=1 with GOLDEN=8'h00.
// - NPAT=1, ram_rdata=8'h5A -> signature=8'h5A.
//   - GOLDEN=8'h5A -> done=1, pass=1.
// - Reset asserted in cycle 3 (RUN), asynchronously:
//   - lfsr_en, ram_wr, busy fall before the next edge.
//   - After release, start works normally.
// - abort=1 during READ -> busy=0 next cycle; done never pulses; pass=0. start during RUN -> no effect.
// - LBIST_LOOP_EN, loop=1, GOLDEN mismatched, 3 sessions -> fail_cnt=3; busy stays 1 throughout.

Source files
------------

// File: rtl/lbist_seq_ctrl_if.sv
// Signal bundle between the LBIST sequencer (master) and its pattern datapath / result RAM (slave).
// loop and fail_cnt exist only when LBIST_LOOP_EN is defined.
interface lbist_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          start;
  logic          abort;
  logic [DW-1:0] ram_rdata;
  logic          lfsr_ld;
  logic          lfsr_en;
  logic [DW-1:0] seed;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic          busy;
  logic          done;
  logic          pass;
  logic [DW-1:0] signature;
`ifdef LBIST_LOOP_EN
  logic          loop;
  logic [7:0]    fail_cnt;

  modport master (
    input  start, abort, ram_rdata, loop,
    output lfsr_ld, lfsr_en, seed, ram_wr, ram_addr, busy, done, pass, signature, fail_cnt
  );
  modport slave (
    output start, abort, ram_rdata, loop,
    input  lfsr_ld, lfsr_en, seed, ram_wr, ram_addr, busy, done, pass, signature, fail_cnt
  );
`else
  modport master (
    input  start, abort, ram_rdata,
    output lfsr_ld, lfsr_en, seed, ram_wr, ram_addr, busy, done, pass, signature
  );
  modport slave (
    output start, abort, ram_rdata,
    input  lfsr_ld, lfsr_en, seed, ram_wr, ram_addr, busy, done, pass, signature
  );
`endif
endinterface

// File: rtl/lbist_seq_ctrl.sv
// LBIST session sequencer: seed LFSR, run NPAT patterns, write results, read back into an 8-bit MISR.
// Optional continuous looping with a saturating fail counter is enabled by defining LBIST_LOOP_EN.
module lbist_seq_ctrl #(
  parameter int            DW     = 8,
  parameter int            AW     = 8,
  parameter int            NPAT   = 200,
  parameter int            LAT    = 2,
  parameter logic [DW-1:0] SEED   = 'h01,
  parameter logic [DW-1:0] GOLDEN = 'hA5
) (
  input logic              clk,
  input logic              reset,
  lbist_seq_ctrl_if.master bus
);
  localparam int CW = $clog2(NPAT + LAT + 2) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_FLUSH, S_READ, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [LAT:0]  r_pipe;     // [0] is lfsr_en, [LAT] is lfsr_en delayed LAT cycles = ram_wr
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_next;
  logic          r_rvld;
  logic [DW-1:0] r_sig;
  logic [DW-1:0] w_sig_step;
  logic [DW-1:0] w_sig_next;
  logic          r_ld;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic          w_en_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == S_IDLE) begin
      if (bus.start && !bus.abort) begin
        w_state_next = S_SEED;
      end
    end else if (bus.abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_SEED: begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
        S_RUN: begin
          if (r_cnt == CW'(NPAT - 1)) begin
            w_state_next = S_FLUSH;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          if (r_cnt == CW'(LAT - 1)) begin
            w_state_next = S_READ;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_READ: begin
          if (r_cnt == CW'(NPAT)) begin
            w_state_next = S_DONE;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
`ifdef LBIST_LOOP_EN
          w_state_next = bus.loop ? S_SEED : S_IDLE;
`else
          w_state_next = S_IDLE;
`endif
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Write address advances after each write; read address tracks the read index and holds on the drain cycle.
  always_comb begin
    w_addr_next = r_addr;
    case (w_state_next)
      S_SEED: w_addr_next = '0;
      S_RUN, S_FLUSH: begin
        if (r_pipe[LAT]) begin
          w_addr_next = r_addr + AW'(1);
        end
      end
      S_READ: begin
        if (w_cnt_next < CW'(NPAT)) begin
          w_addr_next = AW'(w_cnt_next);
        end
      end
      default: w_addr_next = r_addr;
    endcase
  end

  always_comb begin
    w_en_next  = (w_state_next == S_RUN);
    w_sig_step = {r_sig[DW-2:0], r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3]} ^ bus.ram_rdata;
    w_sig_next = r_rvld ? w_sig_step : r_sig;
    if (w_state_next == S_SEED) begin
      w_sig_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pipe  <= '0;
      r_addr  <= '0;
      r_rvld  <= 1'b0;
      r_sig   <= '0;
      r_ld    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pipe  <= (w_state_next == S_IDLE) ? '0 : {r_pipe[LAT-1:0], w_en_next};
      r_addr  <= w_addr_next;
      r_rvld  <= (r_state == S_READ) && (r_cnt < CW'(NPAT)) && (w_state_next != S_IDLE);
      r_sig   <= w_sig_next;
      r_ld    <= (w_state_next == S_SEED);
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      if (w_state_next == S_SEED) begin
        r_pass <= 1'b0;
      end else if (w_state_next == S_DONE) begin
        r_pass <= (w_sig_next == GOLDEN);
      end
    end
  end

`ifdef LBIST_LOOP_EN
  logic [7:0] r_fail_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fail_cnt <= '0;
    end else if (r_state == S_IDLE && w_state_next == S_SEED) begin
      r_fail_cnt <= '0;
    end else if (w_state_next == S_DONE && w_sig_next != GOLDEN && r_fail_cnt != 8'hFF) begin
      r_fail_cnt <= r_fail_cnt + 8'd1;
    end
  end

  assign bus.fail_cnt = r_fail_cnt;
`endif

  assign bus.lfsr_ld   = r_ld;
  assign bus.lfsr_en   = r_pipe[0];
  assign bus.seed      = SEED;
  assign bus.ram_wr    = r_pipe[LAT];
  assign bus.ram_addr  = r_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_sig;
endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// Bench for lbist_seq_ctrl: random result data through a RAM model, timing checked against
// cycle formulas, signature against a reference MISR; loop checks run when LBIST_LOOP_EN is defined.
module tb_lbist_seq_ctrl;
  localparam int         NP   = 4;
  localparam int         LT   = 2;
  localparam int         D    = 2 * NP + LT + 3;
  localparam int         RD0  = NP + LT + 2;
  localparam logic [7:0] GOLD = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] mem [0:255];
  logic [7:0] pat [0:255];

  lbist_seq_ctrl_if #(.DW(8), .AW(8)) bus ();
  lbist_seq_ctrl_if #(.DW(8), .AW(8)) bus1 ();

  lbist_seq_ctrl #(.DW(8), .AW(8), .NPAT(NP), .LAT(LT), .SEED(8'h01), .GOLDEN(GOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  lbist_seq_ctrl #(.DW(8), .AW(8), .NPAT(1), .LAT(2), .SEED(8'h01), .GOLDEN(8'h5A)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  // Result RAM: a write stores the pattern result for that address; read data is registered.
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_addr] <= pat[bus.ram_addr];
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  assign bus1.ram_rdata = 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] misr_ref(input int n);
    logic [7:0] s;
    logic       fb;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      s  = ((s << 1) | {7'd0, fb}) ^ pat[i];
    end
    return s;
  endfunction

  // Expected output pattern for cycle c of a session (c=1 is the SEED cycle).
  task automatic chk_cycle(input int c);
    logic e_ld, e_en, e_wr, e_busy, e_done;
    e_ld   = (c == 1);
    e_en   = (c >= 2 && c <= NP + 1);
    e_wr   = (c >= 2 + LT && c < 2 + LT + NP);
    e_busy = (c >= 1 && c <= D);
    e_done = (c == D);
    chk($sformatf("lfsr_ld c%0d", c), 32'(bus.lfsr_ld), 32'(e_ld));
    chk($sformatf("lfsr_en c%0d", c), 32'(bus.lfsr_en), 32'(e_en));
    chk($sformatf("ram_wr c%0d", c), 32'(bus.ram_wr), 32'(e_wr));
    chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'(e_busy));
    chk($sformatf("done c%0d", c), 32'(bus.done), 32'(e_done));
    if (e_wr) chk($sformatf("wr_addr c%0d", c), 32'(bus.ram_addr), c - 2 - LT);
    if (c >= RD0 && c < RD0 + NP) chk($sformatf("rd_addr c%0d", c), 32'(bus.ram_addr), c - RD0);
    if (c < D) chk($sformatf("pass cleared c%0d", c), 32'(bus.pass), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_session(input string name, input bit poke);
    logic [7:0] es;
    logic       ep;
    es = misr_ref(NP);
    ep = (es == GOLD);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= D + 1; c++) begin
      chk_cycle(c);
      if (c == D) begin
        chk({name, " signature"}, 32'(bus.signature), 32'(es));
        chk({name, " pass"}, 32'(bus.pass), 32'(ep));
      end
      if (c == D + 1) chk({name, " pass held"}, 32'(bus.pass), 32'(ep));
      bus.start = poke && (c >= 2 && c <= 4);
      @(negedge clk);
    end
    bus.start = 1'b0;
    $display("session %s: signature=%02h expected=%02h pass=%0b", name, bus.signature, es, bus.pass);
  endtask

  initial begin
    logic [7:0] s;
    int         seen;
    int         c1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
`ifdef LBIST_LOOP_EN
    bus.loop   = 1'b0;
    bus1.loop  = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      pat[i] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset pass", 32'(bus.pass), 32'd0);
    chk("reset signature", 32'(bus.signature), 32'd0);
    chk("reset lfsr_ld", 32'(bus.lfsr_ld), 32'd0);
    chk("reset lfsr_en", 32'(bus.lfsr_en), 32'd0);
    chk("reset ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("reset ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("reset seed", 32'(bus.seed), 32'h01);
    reset = 1'b0;
    @(negedge clk);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("idle start+abort busy", 32'(bus.busy), 32'd0);
    chk("idle start+abort lfsr_ld", 32'(bus.lfsr_ld), 32'd0);
    $display("start+abort in idle: busy=%0b", bus.busy);
    @(negedge clk);

    for (int i = 0; i < NP; i++) pat[i] = 8'($urandom);
    run_session("random+start_poke", 1'b1);

    for (int i = 0; i < NP; i++) pat[i] = 8'h00;
    run_session("zeros", 1'b0);

    for (int i = 0; i < NP - 1; i++) pat[i] = 8'($urandom);
    s = misr_ref(NP - 1);
    pat[NP-1] = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ GOLD;
    run_session("golden_match", 1'b0);

    for (int i = 0; i < NP; i++) pat[i] = 8'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort pre busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort lfsr_en", 32'(bus.lfsr_en), 32'd0);
    chk("abort ram_wr", 32'(bus.ram_wr), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("abort no done", seen, 0);
    chk("abort pass", 32'(bus.pass), 32'd0);
    $display("abort in READ: busy=%0b done_pulses=%0d pass=%0b", bus.busy, seen, bus.pass);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset lfsr_en", 32'(bus.lfsr_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 32'(bus.busy), 32'd0);
    chk("async reset lfsr_en", 32'(bus.lfsr_en), 32'd0);
    chk("async reset ram_wr", 32'(bus.ram_wr), 32'd0);
    $display("async reset in RUN: busy=%0b lfsr_en=%0b ram_wr=%0b", bus.busy, bus.lfsr_en, bus.ram_wr);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NP; i++) pat[i] = 8'($urandom);
    run_session("after_reset", 1'b0);

    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    c1 = 1;
    while (!bus1.done && c1 < 30) begin
      @(negedge clk);
      c1++;
    end
    chk("npat1 done cycle", c1, 7);
    chk("npat1 signature", 32'(bus1.signature), 32'h5A);
    chk("npat1 pass", 32'(bus1.pass), 32'd1);
    $display("session npat1: done_cycle=%0d signature=%02h pass=%0b", c1, bus1.signature, bus1.pass);
    @(negedge clk);

`ifdef LBIST_LOOP_EN
    begin
      int ndone;
      int busy_low;
      int cyc;
      for (int i = 0; i < NP; i++) pat[i] = 8'h00;
      bus.loop  = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("loop fail_cnt cleared", 32'(bus.fail_cnt), 32'd0);
      ndone = 0;
      busy_low = 0;
      cyc = 0;
      while (cyc < 200) begin
        if (!bus.busy) busy_low++;
        if (bus.done) ndone++;
        if (ndone == 3) break;
        @(negedge clk);
        cyc++;
      end
      bus.loop = 1'b0;
      chk("loop done count", ndone, 3);
      chk("loop fail_cnt", 32'(bus.fail_cnt), 32'd3);
      chk("loop busy gaps", busy_low, 0);
      @(negedge clk);
      chk("loop exit busy", 32'(bus.busy), 32'd0);
      $display("loop sessions=%0d fail_cnt=%0d", ndone, bus.fail_cnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
